// File: rtl/wimax_interleaver.sv
// WiMAX QPSK-1/2 block interleaver: serial in, first-stage permutation, serial out.
// Two 192-bit banks in one 384x1 RAM run ping-pong so a continuous input gives a continuous output.
module wimax_interleaver #(
  parameter int NCBPS = 192,
  parameter int D     = 16
) (
  input  logic clk_100MHz,
  input  logic rst_n,
  input  logic data_in,
  input  logic valid_in,
  output logic ready_out,
  output logic valid_out,
  output logic serial_out
);

  localparam int         ROWS     = NCBPS / D;
  localparam logic [7:0] LAST     = 8'(NCBPS - 1);
  localparam logic [7:0] STEP     = 8'(ROWS);
  localparam logic [3:0] COL_LAST = 4'(D - 1);
  localparam logic [8:0] BANK_OFS = 9'(NCBPS);

  typedef enum logic {S_IDLE, S_DRAIN} state_t;

  // Handshake: a bit moves on every rising edge where valid_in && ready_out;
  // valid_out marks serial_out as meaningful, and there is no downstream backpressure.
  logic       r_init;
  logic       r_wr_bank;
  logic [7:0] r_wr_cnt;
  logic [7:0] r_wr_addr;
  logic [3:0] r_row;
  logic [3:0] r_col;
  logic [1:0] r_full;
  state_t     r_state;
  logic       r_rd_bank;
  logic [7:0] r_rd_cnt;
  logic       r_rd_valid;
  logic       r_rd_data;
  logic       r_valid_out;
  logic       r_serial_out;
  logic       r_mem [0:2*NCBPS-1];

  logic       w_rd_en;
  logic       w_rd_fire;
  logic       w_rd_last;
  logic       w_ready;
  logic       w_accept;
  logic       w_wr_done;
  logic [8:0] w_wr_phys;
  logic [8:0] w_rd_phys;
  logic [1:0] w_full_nxt;
  state_t     w_state_nxt;
  logic       w_rd_bank_nxt;
  logic [7:0] w_rd_cnt_nxt;

  // Read-side enable; tied high, kept as a named net so the read side can be stalled in simulation.
  assign w_rd_en   = 1'b1;
  assign w_rd_fire = w_rd_en && (r_state == S_DRAIN);
  assign w_rd_last = w_rd_fire && (r_rd_cnt == LAST);
  assign w_ready   = r_init && (!r_full[r_wr_bank] || (w_rd_last && (r_rd_bank == r_wr_bank)));
  assign w_accept  = valid_in && w_ready;
  assign w_wr_done = w_accept && (r_wr_cnt == LAST);
  assign w_wr_phys = {1'b0, r_wr_addr} + (r_wr_bank ? BANK_OFS : 9'd0);
  assign w_rd_phys = {1'b0, r_rd_cnt} + (r_rd_bank ? BANK_OFS : 9'd0);

  // Write address walks m(k) = 12*(k mod 16) + k/16 with an add-12 / restart-at-row+1 scheme.
  always_ff @(posedge clk_100MHz or negedge rst_n) begin
    if (!rst_n) begin
      r_init    <= 1'b0;
      r_wr_bank <= 1'b0;
      r_wr_cnt  <= 8'd0;
      r_wr_addr <= 8'd0;
      r_row     <= 4'd0;
      r_col     <= 4'd0;
    end else begin
      r_init <= 1'b1;
      if (w_accept) begin
        if (w_wr_done) begin
          r_wr_bank <= ~r_wr_bank;
          r_wr_cnt  <= 8'd0;
          r_wr_addr <= 8'd0;
          r_row     <= 4'd0;
          r_col     <= 4'd0;
        end else begin
          r_wr_cnt <= r_wr_cnt + 8'd1;
          if (r_col == COL_LAST) begin
            r_col     <= 4'd0;
            r_row     <= r_row + 4'd1;
            r_wr_addr <= {4'd0, r_row} + 8'd1;
          end else begin
            r_col     <= r_col + 4'd1;
            r_wr_addr <= r_wr_addr + STEP;
          end
        end
      end
    end
  end

  always_comb begin
    w_full_nxt = r_full;
    if (w_rd_last) w_full_nxt[r_rd_bank] = 1'b0;
    if (w_wr_done) w_full_nxt[r_wr_bank] = 1'b1;
  end

  // A block completing this cycle counts as full, so draining starts on the same edge.
  always_comb begin
    w_state_nxt   = r_state;
    w_rd_bank_nxt = r_rd_bank;
    w_rd_cnt_nxt  = r_rd_cnt;
    if (w_rd_en) begin
      case (r_state)
        S_IDLE: begin
          if ((|r_full) || w_wr_done) begin
            w_state_nxt   = S_DRAIN;
            w_rd_cnt_nxt  = 8'd0;
            w_rd_bank_nxt = (r_full[~r_wr_bank] && !r_full[r_wr_bank]) ? ~r_wr_bank : r_wr_bank;
          end
        end
        S_DRAIN: begin
          if (r_rd_cnt == LAST) begin
            if (r_full[~r_rd_bank] || (w_wr_done && (r_wr_bank != r_rd_bank))) begin
              w_rd_bank_nxt = ~r_rd_bank;
              w_rd_cnt_nxt  = 8'd0;
            end else begin
              w_state_nxt = S_IDLE;
            end
          end else begin
            w_rd_cnt_nxt = r_rd_cnt + 8'd1;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_100MHz or negedge rst_n) begin
    if (!rst_n) begin
      r_full       <= 2'b00;
      r_state      <= S_IDLE;
      r_rd_bank    <= 1'b0;
      r_rd_cnt     <= 8'd0;
      r_rd_valid   <= 1'b0;
      r_valid_out  <= 1'b0;
      r_serial_out <= 1'b0;
    end else begin
      r_full       <= w_full_nxt;
      r_state      <= w_state_nxt;
      r_rd_bank    <= w_rd_bank_nxt;
      r_rd_cnt     <= w_rd_cnt_nxt;
      r_rd_valid   <= w_rd_fire;
      r_valid_out  <= r_rd_valid;
      r_serial_out <= r_rd_valid & r_rd_data;
    end
  end

  always_ff @(posedge clk_100MHz) begin
    if (w_accept)  r_mem[w_wr_phys] <= data_in;
    if (w_rd_fire) r_rd_data        <= r_mem[w_rd_phys];
  end

  assign ready_out  = w_ready;
  assign valid_out  = r_valid_out;
  assign serial_out = r_serial_out;

endmodule

// File: tb/tb_wimax_interleaver.sv
// Bench for wimax_interleaver: random and one-hot blocks against a permutation model
// out[12*(k%16) + k/16] = in[k], with latency, continuity, stall and reset scenarios.
module tb_wimax_interleaver;

  logic clk = 1'b0;
  logic rst_n;
  logic data_in;
  logic valid_in;
  logic ready_out;
  logic valid_out;
  logic serial_out;

  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;
  logic exp_q[$];
  int   start_q[$];
  int   out_pos = 0;
  int   blk_start = 0;
  int   last_start = -1;
  int   last_t = 0;
  int   acc_cyc = 0;
  bit   mon_en = 1'b0;
  bit   chk_timing = 1'b1;
  logic mon_exp;

  wimax_interleaver #(.NCBPS(192), .D(16)) dut (
    .clk_100MHz (clk),
    .rst_n      (rst_n),
    .data_in    (data_in),
    .valid_in   (valid_in),
    .ready_out  (ready_out),
    .valid_out  (valid_out),
    .serial_out (serial_out)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard: output stream against the model queue, plus start/continuity timing
  always @(negedge clk) begin
    if (rst_n && mon_en) begin
      if (valid_out === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL unexpected_output cyc=%0d serial_out=%b expected no output", cyc, serial_out);
        end else begin
          mon_exp = exp_q.pop_front();
          if (out_pos == 0) begin
            last_start = cyc;
            blk_start  = (start_q.size() > 0) ? start_q.pop_front() : cyc;
            if (!chk_timing) blk_start = cyc;
          end
          n_vec++;
          if (serial_out !== mon_exp) begin
            n_err++;
            $display("FAIL out_data pos=%0d cyc=%0d got=%b exp=%b", out_pos, cyc, serial_out, mon_exp);
          end
          if (chk_timing) begin
            n_vec++;
            if (cyc !== blk_start + out_pos) begin
              n_err++;
              $display("FAIL out_timing pos=%0d got_cyc=%0d exp_cyc=%0d", out_pos, cyc, blk_start + out_pos);
            end
          end
          out_pos = (out_pos == 191) ? 0 : out_pos + 1;
        end
      end else begin
        n_vec++;
        if (serial_out !== 1'b0) begin
          n_err++;
          $display("FAIL idle_serial cyc=%0d got=%b exp=0", cyc, serial_out);
        end
      end
    end
  end

  function automatic logic [191:0] rand_block();
    logic [191:0] v;
    for (int i = 0; i < 6; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // driver: call at #1 after a rising edge; returns #1 after the accepting edge
  task automatic send_bit(input logic b);
    int w;
    data_in  = b;
    valid_in = 1'b1;
    w = 0;
    @(negedge clk);
    while (ready_out !== 1'b1 && w < 1000) begin
      @(negedge clk);
      w++;
    end
    if (ready_out !== 1'b1) begin
      n_vec++; n_err++;
      $display("FAIL send_timeout cyc=%0d ready_out=%b exp=1", cyc, ready_out);
    end
    @(posedge clk);
    #1;
    acc_cyc  = cyc;
    valid_in = 1'b0;
    data_in  = 1'b0;
  endtask

  task automatic send_block(input logic [191:0] bits, input int gap_k, input int gap_len,
                            input int tail_gap);
    logic blk [0:191];
    for (int k = 0; k < 192; k++) begin
      send_bit(bits[k]);
      if (k == gap_k && k < 191) repeat (gap_len) begin @(posedge clk); #1; end
    end
    for (int k = 0; k < 192; k++) blk[12*(k%16) + k/16] = bits[k];
    for (int p = 0; p < 192; p++) exp_q.push_back(blk[p]);
    start_q.push_back(acc_cyc + 2);
    last_t = acc_cyc;
    repeat (tail_gap) begin @(posedge clk); #1; end
  endtask

  task automatic wait_idle();
    int w;
    w = 0;
    while (exp_q.size() != 0 && w < 3000) begin
      @(negedge clk);
      w++;
    end
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain_timeout remaining=%0d exp=0", exp_q.size());
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    valid_in = 1'b0;
    data_in  = 1'b0;
    repeat (3) @(negedge clk);
    n_vec++; if (ready_out !== 1'b0) begin n_err++; $display("FAIL rst_ready got=%b exp=0", ready_out); end
    n_vec++; if (valid_out !== 1'b0) begin n_err++; $display("FAIL rst_valid got=%b exp=0", valid_out); end
    n_vec++; if (serial_out !== 1'b0) begin n_err++; $display("FAIL rst_serial got=%b exp=0", serial_out); end
    rst_n = 1'b1;
    @(negedge clk);
    n_vec++; if (ready_out !== 1'b1) begin n_err++; $display("FAIL rst_release_ready got=%b exp=1", ready_out); end
    mon_en = 1'b1;
  endtask

  task automatic test_one_hot(input int k, input int exp_pos);
    logic [191:0] bits;
    int ones, one_cyc;
    bits = '0;
    bits[k] = 1'b1;
    @(posedge clk); #1;
    send_block(bits, -1, 0, 0);
    ones = 0;
    one_cyc = -1;
    repeat (200) begin
      @(negedge clk);
      if (valid_out === 1'b1 && serial_out === 1'b1) begin
        ones++;
        one_cyc = cyc;
      end
    end
    n_vec++;
    if (ones !== 1) begin n_err++; $display("FAIL one_hot_count k=%0d got=%0d exp=1", k, ones); end
    n_vec++;
    if (one_cyc !== last_t + 2 + exp_pos) begin
      n_err++;
      $display("FAIL one_hot_pos k=%0d got_cyc=%0d exp_cyc=%0d", k, one_cyc, last_t + 2 + exp_pos);
    end
    wait_idle();
  endtask

  task automatic test_sweep();
    logic [191:0] bits;
    @(posedge clk); #1;
    for (int k = 0; k < 192; k++) begin
      bits = '0;
      bits[k] = 1'b1;
      send_block(bits, -1, 0, 0);
    end
    wait_idle();
  endtask

  task automatic test_back_to_back();
    int cnt, first, last, rdy_lo;
    cnt = 0; first = -1; last = -1; rdy_lo = 0;
    @(posedge clk); #1;
    fork
      begin
        for (int b = 0; b < 3; b++) send_block(rand_block(), -1, 0, 0);
      end
      begin
        repeat (3*192 + 220) begin
          @(negedge clk);
          if (valid_out === 1'b1) begin
            cnt++;
            if (first < 0) first = cyc;
            last = cyc;
          end
          if (ready_out !== 1'b1) rdy_lo++;
        end
      end
    join
    n_vec++; if (cnt !== 576) begin n_err++; $display("FAIL b2b_count got=%0d exp=576", cnt); end
    n_vec++;
    if (last - first + 1 !== 576) begin
      n_err++; $display("FAIL b2b_contiguous got_span=%0d exp=576", last - first + 1);
    end
    n_vec++; if (rdy_lo !== 0) begin n_err++; $display("FAIL b2b_ready_drop got=%0d exp=0", rdy_lo); end
    wait_idle();
  endtask

  task automatic test_gaps();
    @(posedge clk); #1;
    send_block(rand_block(), 50, 7, 3);
    wait_idle();
    n_vec++;
    if (last_start !== last_t + 2) begin
      n_err++; $display("FAIL gap_start got_cyc=%0d exp_cyc=%0d", last_start, last_t + 2);
    end
  endtask

  task automatic test_stall();
    int rdy_hi;
    chk_timing = 1'b0;
    force dut.w_rd_en = 1'b0;
    @(posedge clk); #1;
    send_block(rand_block(), -1, 0, 0);
    send_block(rand_block(), -1, 0, 0);
    @(negedge clk);
    n_vec++; if (ready_out !== 1'b0) begin n_err++; $display("FAIL stall_ready got=%b exp=0", ready_out); end
    n_vec++; if (valid_out !== 1'b0) begin n_err++; $display("FAIL stall_valid got=%b exp=0", valid_out); end
    @(posedge clk); #1;
    rdy_hi = 0;
    fork
      send_block(rand_block(), -1, 0, 0);
      begin
        repeat (20) begin
          @(negedge clk);
          if (ready_out !== 1'b0) rdy_hi++;
        end
        release dut.w_rd_en;
      end
    join
    n_vec++; if (rdy_hi !== 0) begin n_err++; $display("FAIL stall_hold got=%0d exp=0", rdy_hi); end
    wait_idle();
    chk_timing = 1'b1;
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1;
    send_block(rand_block(), -1, 0, 0);
    for (int k = 0; k <= 100; k++) send_bit(1'($urandom_range(0, 1)));
    n_vec++; if (valid_out !== 1'b1) begin n_err++; $display("FAIL mid_draining got=%b exp=1", valid_out); end
    rst_n = 1'b0;
    #1;
    n_vec++; if (valid_out !== 1'b0) begin n_err++; $display("FAIL mid_rst_valid got=%b exp=0", valid_out); end
    n_vec++; if (serial_out !== 1'b0) begin n_err++; $display("FAIL mid_rst_serial got=%b exp=0", serial_out); end
    n_vec++; if (ready_out !== 1'b0) begin n_err++; $display("FAIL mid_rst_ready got=%b exp=0", ready_out); end
    exp_q.delete();
    start_q.delete();
    out_pos = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    @(posedge clk); #1;
    send_block(rand_block(), -1, 0, 0);
    wait_idle();
    n_vec++;
    if (last_start !== last_t + 2) begin
      n_err++; $display("FAIL mid_fresh_start got_cyc=%0d exp_cyc=%0d", last_start, last_t + 2);
    end
  endtask

  initial begin
    test_reset();
    test_one_hot(1, 12);
    test_one_hot(16, 1);
    test_one_hot(191, 191);
    test_one_hot(0, 0);
    test_sweep();
    test_back_to_back();
    test_gaps();
    test_stall();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
